// File: rtl/booth_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and a two's-complement conditional negate helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int MAXW      = 64;

    // Callers size-cast operands to MAXW and the result back to their width;
    // the low bits of a wide negate equal the narrow negate, so -2^(W-1) maps to itself.
    function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] v, input logic en);
        logic [MAXW-1:0] res;
        if (en) begin
            res = ~v + 64'd1;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// trial-subtract the divisor magnitude in WIDTH+1 bits.
module div_restore_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_sub_b;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    assign w_sub_b = ~{1'b0, i_dvsr};
    assign w_trial = w_shift + w_sub_b + {{WIDTH{1'b0}}, 1'b1};

    // A restored remainder is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        o_qbit = ~w_trial[WIDTH];
        if (o_qbit) begin
            o_rem = w_trial[WIDTH-1:0];
        end else begin
            o_rem = w_shift[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/booth_seq_divider.sv
// Multi-cycle signed divider: restoring loop on magnitudes, sign fix-up,
// truncation toward zero, valid/ready handshakes on both sides.
module booth_seq_divider
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_qsr;
    logic [WIDTH-1:0] r_dmag;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ovf_case;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;
    logic             w_dvd_min;
    logic             w_dvs_m1;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;

    assign w_dvd_mag = WIDTH'(cond_neg(MAXW'(dividend), dividend[WIDTH-1]));
    assign w_dvs_mag = WIDTH'(cond_neg(MAXW'(divisor), divisor[WIDTH-1]));
    assign w_q_fixed = WIDTH'(cond_neg(MAXW'(r_qsr), r_sign_q));
    assign w_r_fixed = WIDTH'(cond_neg(MAXW'(r_p), r_sign_r));
    assign w_dvd_min = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_dvs_m1  = (divisor == {WIDTH{1'b1}});

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_p),
        .i_bit  (r_qsr[WIDTH-1]),
        .i_dvsr (r_dmag),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // Divider control FSM with datapath and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= {CW{1'b0}};
            r_p           <= {WIDTH{1'b0}};
            r_qsr         <= {WIDTH{1'b0}};
            r_dmag        <= {WIDTH{1'b0}};
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_ovf_case    <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_quotient    <= {WIDTH{1'b0}};
            r_remainder   <= {WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready    <= 1'b0;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_sign_r      <= dividend[WIDTH-1];
                        r_dmag        <= w_dvs_mag;
                        r_ovf_case    <= w_dvd_min & w_dvs_m1;
                        if (divisor == {WIDTH{1'b0}}) begin
                            r_quotient    <= {WIDTH{1'b1}};
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_p     <= {WIDTH{1'b0}};
                            r_qsr   <= w_dvd_mag;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_p   <= w_step_rem;
                    r_qsr <= {r_qsr[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quotient  <= w_q_fixed;
                    r_remainder <= w_r_fixed;
                    r_overflow  <= r_ovf_case;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed self-checking bench for booth_seq_divider at WIDTH=4.
module tb_booth_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dividend = 4'h0;
    logic [3:0] divisor = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    booth_seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Vectors: dividend, divisor, quotient, remainder, div_by_zero, overflow, latency.
    logic [3:0] v_a   [0:9] = '{4'h7, 4'h9, 4'h7, 4'hA, 4'h8, 4'h8, 4'h0, 4'h1, 4'h5, 4'h3};
    logic [3:0] v_b   [0:9] = '{4'h2, 4'h2, 4'hE, 4'hD, 4'hF, 4'h1, 4'h5, 4'h8, 4'h0, 4'h3};
    logic [3:0] v_q   [0:9] = '{4'h3, 4'hD, 4'hD, 4'h2, 4'h8, 4'h8, 4'h0, 4'h0, 4'hF, 4'h1};
    logic [3:0] v_r   [0:9] = '{4'h1, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h5, 4'h0};
    logic       v_dbz [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       v_ovf [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int         v_lat [0:9] = '{6, 6, 6, 6, 6, 6, 6, 6, 1, 6};

    task automatic start_div(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 4'h0;
        divisor  = 4'h0;
    endtask

    // Returns the cycle offset (1 = T+1) at which out_valid is first seen, 0 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop_result;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs q=%h r=%h dbz=%b ovf=%b want 0", quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_divide_table;
        int lat;
        for (int k = 0; k < 10; k++) begin
            start_div(v_a[k], v_b[k]);
            wait_result(lat);
            checks++;
            if (lat !== v_lat[k]) begin
                errors++;
                $display("FAIL latency[%0d] got %0d want %0d", k, lat, v_lat[k]);
            end
            checks++;
            if (quotient !== v_q[k]) begin
                errors++;
                $display("FAIL quotient[%0d] %h/%h got %h want %h", k, v_a[k], v_b[k], quotient, v_q[k]);
            end
            checks++;
            if (remainder !== v_r[k]) begin
                errors++;
                $display("FAIL remainder[%0d] %h/%h got %h want %h", k, v_a[k], v_b[k], remainder, v_r[k]);
            end
            checks++;
            if (div_by_zero !== v_dbz[k]) begin
                errors++;
                $display("FAIL div_by_zero[%0d] got %b want %b", k, div_by_zero, v_dbz[k]);
            end
            checks++;
            if (overflow !== v_ovf[k]) begin
                errors++;
                $display("FAIL overflow[%0d] got %b want %b", k, overflow, v_ovf[k]);
            end
            pop_result();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL release[%0d] out_valid=%b in_ready=%b want 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold;
        int lat;
        start_div(4'h7, 4'h2);
        wait_result(lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL hold_latency got %0d want 6", lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 4'h1;
            divisor  = 4'h1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 4'h3 || remainder !== 4'h1) begin
                errors++;
                $display("FAIL hold[%0d] ov=%b ir=%b q=%h r=%h want 1/0/3/1", i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        pop_result();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        start_div(4'h7, 4'h2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_result out_valid seen=%b want 0", seen);
        end
        start_div(4'h6, 4'h4);
        wait_result(lat);
        checks++;
        if (lat !== 6 || quotient !== 4'h1 || remainder !== 4'h2) begin
            errors++;
            $display("FAIL after_reset lat=%0d q=%h r=%h want 6/1/2", lat, quotient, remainder);
        end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_divide_table();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
Multi-cycle signed integer divider, the inverse of the Booth multiplier datapath. It takes an N-bit signed dividend and divisor and returns an N-bit quotient and remainder. Division truncates toward zero, and the remainder takes the sign of the dividend. It runs a radix-2 restoring shift/subtract loop on magnitudes, with sign correction at the end, behind valid/ready handshakes on both input and output.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (signed, two's complement; minimum 2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  divider can accept operands
dividend  input  WIDTH  signed dividend
divisor  input  WIDTH  signed divisor
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  signed quotient
remainder  output  WIDTH  signed remainder
div_by_zero  output  1  result flag: divisor was 0
overflow  output  1  result flag: dividend = -2^(WIDTH-1) and divisor = -1

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - quotient, remainder, div_by_zero, overflow = 0; iteration counter = 0.
- Reset mid-operation aborts immediately. No result is produced and the accepted operands are lost.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1. Operands are accepted when in_valid & in_ready (accept cycle = T).
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Latch |dividend| and |divisor| as WIDTH-bit unsigned values. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - divisor == 0: go directly to DONE.
  - Otherwise: clear the WIDTH+1-bit partial remainder, load the dividend magnitude into the quotient shift register, counter = WIDTH, go to CALC.
- CALC, one bit per cycle, WIDTH cycles:
  - trial = {P[WIDTH-1:0], Qsr[WIDTH-1]} - {0, |divisor|}, computed in WIDTH+1 bits.
  - If trial is non-negative: P = trial and shift 1 into Qsr.
  - Otherwise: P = the shifted value (restore) and shift 0 into Qsr.
  - Decrement counter; when the counter reaches 0, go to FIX.
- FIX, one cycle:
  - quotient = sign_q ? -Qsr : Qsr.
  - remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - overflow = (dividend was -2^(WIDTH-1)) & (divisor was -1). In that case the quotient naturally wraps to -2^(WIDTH-1) and the remainder is 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; outputs and flags are stable while out_valid & !out_ready.
  - When out_valid & out_ready: out_valid = 0, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Divide by zero:
  - quotient = all ones (-1), remainder = dividend unchanged, div_by_zero = 1, overflow = 0.
  - out_valid rises at T+1.
- Normal latency:
  - out_valid rises at T+WIDTH+2 (T+6 for WIDTH=4). Throughput is one division per WIDTH+3 cycles minimum.
- in_ready = 0 in CALC, FIX and DONE. Operand changes on the input bus while busy are ignored.
- Flags are cleared on each new accept. Flags and results are valid only while out_valid = 1.
- Width rules:
  - All arithmetic is WIDTH+1 bits internally; no result exceeds WIDTH bits except the overflow case, which wraps as stated.
  - 0 / x gives quotient 0, remainder 0.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - default WIDTH constant;
  - helper function for two's-complement negate/abs.
- One sub-module, div_restore_step: combinational single iteration.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Built on the existing add/subtract style (XOR-invert plus carry-in of 1).

Test Plan:
- WIDTH=4, 7 / 2 -> quotient 3, remainder 1, flags 0; out_valid exactly 6 cycles after accept.
- -7 / 2 -> quotient -3 (4'hD), remainder -1 (4'hF); and 7 / -2 -> quotient -3, remainder 1; and -6 / -3 -> quotient 2, remainder 0.
- -8 / -1 -> quotient -8 (4'h8), remainder 0, overflow = 1; and -8 / 1 -> quotient -8, overflow = 0.
- 5 / 0 -> quotient 4'hF, remainder 5, div_by_zero = 1, out_valid 1 cycle after accept; the following 3 / 3 has flags cleared, quotient 1, remainder 0.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, new in_valid ignored; out_ready pulse -> out_valid falls, in_ready = 1 the next cycle.
- Assert rst during CALC (cycle T+3) -> out_valid = 0 and in_ready = 1 immediately; no result appears. The next division 6 / 4 -> quotient 1, remainder 2.
